hazard_scheduler: RTL
=====================

# hazard_scheduler

Pipeline hazard and issue controller for the five-stage MIPS core. It sits beside the ID stage and tracks destination registers of instructions in flight in EXE and MEM. Each cycle it decides whether the instruction in ID issues, stalls (bubble into EXE) or is followed by a flush of IF/ID on a taken branch. With forwarding compiled in, it also produces registered operand-forwarding selects for the EXE stage.

## Interface
Parameters:
- REG_AW, 5, register address width
- CNT_W, 16, width of stall-cycle counter

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- id_valid  input  1  ID holds a valid instruction
- src1  input  REG_AW  first source register of ID instruction
- src2  input  REG_AW  second source register (rt, or rs for store/BNE)
- src1_used, src2_used  input  1 each  source actually read from register file
- dest  input  REG_AW  destination register of ID instruction
- wb_en  input  1  ID instruction writes back
- mem_r_en  input  1  ID instruction is a load
- br_taken  input  1  branch condition resolved taken in ID
- freeze  input  1  external pipeline freeze (memory wait), holds everything
- hazard_stall  output  1  hold PC and IF/ID, insert bubble into ID/EXE
- issue  output  1  ID instruction advances into EXE this cycle
- flush  output  1  squash instruction in IF/ID at next edge
- fwd_sel_a, fwd_sel_b  output  2 each  EXE operand source: 00 reg/ID value, 01 MEM-stage ALU result, 10 WB-stage value, 11 unused
- stall_count  output  CNT_W  saturating count of hazard-stall cycles

## Operation
- Tracking table: slot0 = instruction now in EXE, slot1 = now in MEM; each slot holds {valid, dest, wr, ld}.
- Entry written: wr = wb_en & (dest != 0); ld = mem_r_en. Register 0 never creates a hazard.
- Match(s, k): s used, s != 0, slot k valid & wr & dest == s.
- Register file is write-through: WB-stage writes are visible to same-cycle ID reads; WB is never tracked.
- hazard_stall (combinational) = id_valid & any required stall condition (see Configuration).
- issue = id_valid & !hazard_stall & !freeze.
- flush = br_taken & issue. A branch with a pending hazard stalls first; br_taken is ignored until it issues.
- Table advance when !freeze: slot1 <= slot0; slot0 <= issue ? new entry : empty.
- fwd_sel registers when !freeze: on issue, computed per source (slot0 match -> 01, else slot1 match -> 10, else 00; slot0 has priority); on no issue -> 00.
- stall_count increments when hazard_stall & !freeze, saturates at all-ones.
- freeze: table, fwd_sel, stall_count hold; issue = 0, flush = 0.

## Timing
- Reset (rst low, asynchronous): table invalid, fwd_sel_a/b = 00, stall_count = 0; hence hazard_stall = 0, issue = id_valid, flush = br_taken & id_valid. Reset mid-stall drops the stall immediately.
- hazard_stall, issue, flush: combinational from inputs and current table, same cycle.
- fwd_sel: registered, valid during the consumer's EXE cycle (one cycle after its issue).
- Dependent distance 1 (consumer directly behind producer) sees producer in slot0; distance 2 sees slot1; distance 3+ reads register file.
- Simultaneous freeze and hazard: no count, no advance.

## Configuration
- FORWARDING_EN defined: stall only on load-use, i.e. match in slot0 with ld = 1 (1 bubble); all other matches resolved by fwd_sel. After the load bubble the producer is in slot1 and fwd_sel = 10.
- FORWARDING_EN undefined: stall on any match in slot0 or slot1 (up to 2 bubbles); fwd_sel_a/b tied to 00 and their registers omitted.

## Test plan
- Reset mid-operation: fill both slots with writes to R5, stalled consumer of R5, pull rst low -> hazard_stall 0, fwd_sel 00, stall_count 0 same cycle.
- No FORWARDING_EN: ADD R3 then ADD reading R3 -> hazard_stall 2 cycles, issue on third, stall_count = 2.
- FORWARDING_EN: ADD R3, ADD reads R3 (src1), ADD reads R3 (src2) -> no stall; fwd_sel_a = 01 in second's EXE; fwd_sel_b = 10 in third's EXE.
- FORWARDING_EN: LW R4, then ADD reads R4 -> exactly 1 stall, then fwd_sel = 10; writes to R0 followed by R0 reads -> no stall, fwd 00.
- Taken branch with no hazard -> flush = 1 for one cycle; branch depending on prior LW -> flush asserted only in the cycle it issues, never during stall.
- freeze held 3 cycles during a stall -> table, fwd_sel, stall_count unchanged, issue = 0; release -> sequence resumes identically; stall_count saturates at 2^CNT_W-1.

Source files
------------

// File: rtl/hazard_scheduler.sv
// Hazard/issue controller beside ID: tracks EXE/MEM destinations, decides issue, stall or flush.
// Build option FORWARDING_EN: stall only on load-use and drive registered EXE forwarding selects.
module hazard_scheduler #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] src1,
  input  logic [REG_AW-1:0] src2,
  input  logic              src1_used,
  input  logic              src2_used,
  input  logic [REG_AW-1:0] dest,
  input  logic              wb_en,
  input  logic              mem_r_en,
  input  logic              br_taken,
  input  logic              freeze,
  output logic              hazard_stall,
  output logic              issue,
  output logic              flush,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic [CNT_W-1:0]  stall_count
);

  // slot0 = instruction now in EXE, slot1 = now in MEM. A load's ld bit only matters while in EXE.
  logic              s0_valid;
  logic              s0_wr;
  logic              s0_ld;
  logic [REG_AW-1:0] s0_dest;
  logic              s1_valid;
  logic              s1_wr;
  logic [REG_AW-1:0] s1_dest;

  function automatic logic src_match(input logic              used,
                                     input logic [REG_AW-1:0] src,
                                     input logic              slot_valid,
                                     input logic              slot_wr,
                                     input logic [REG_AW-1:0] slot_dest);
    return used && (src != '0) && slot_valid && slot_wr && (slot_dest == src);
  endfunction

  logic m1_s0, m2_s0, m1_s1, m2_s1;
  logic need_stall;

  assign m1_s0 = src_match(src1_used, src1, s0_valid, s0_wr, s0_dest);
  assign m2_s0 = src_match(src2_used, src2, s0_valid, s0_wr, s0_dest);
  assign m1_s1 = src_match(src1_used, src1, s1_valid, s1_wr, s1_dest);
  assign m2_s1 = src_match(src2_used, src2, s1_valid, s1_wr, s1_dest);

`ifdef FORWARDING_EN
  assign need_stall = (m1_s0 || m2_s0) && s0_ld;
`else
  assign need_stall = m1_s0 || m2_s0 || m1_s1 || m2_s1;
`endif

  assign hazard_stall = id_valid && need_stall;
  assign issue        = id_valid && !hazard_stall && !freeze;
  // A branch waiting on a hazard only resolves once it actually issues.
  assign flush        = br_taken && issue;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_valid <= 1'b0;
      s0_wr    <= 1'b0;
      s0_ld    <= 1'b0;
      s0_dest  <= '0;
      s1_valid <= 1'b0;
      s1_wr    <= 1'b0;
      s1_dest  <= '0;
    end else if (!freeze) begin
      s1_valid <= s0_valid;
      s1_wr    <= s0_wr;
      s1_dest  <= s0_dest;
      s0_valid <= issue;
      s0_wr    <= wb_en && (dest != '0);
      s0_ld    <= mem_r_en;
      s0_dest  <= dest;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (hazard_stall && !freeze && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

`ifdef FORWARDING_EN
  // The EXE producer is the most recent writer, so slot0 wins over slot1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_sel_a <= 2'b00;
      fwd_sel_b <= 2'b00;
    end else if (!freeze) begin
      if (issue) begin
        fwd_sel_a <= m1_s0 ? 2'b01 : (m1_s1 ? 2'b10 : 2'b00);
        fwd_sel_b <= m2_s0 ? 2'b01 : (m2_s1 ? 2'b10 : 2'b00);
      end else begin
        fwd_sel_a <= 2'b00;
        fwd_sel_b <= 2'b00;
      end
    end
  end
`else
  assign fwd_sel_a = 2'b00;
  assign fwd_sel_b = 2'b00;
`endif

endmodule
